// File: rtl/stream_in_packer_pkg.sv
// Shared stream definitions: block type codes, packer FSM encoding and width constants.
// Also reused by the cipher core that consumes the packed blocks.
package stream_in_packer_pkg;

    localparam int unsigned WordW         = 32;
    localparam int unsigned BlockW        = 128;
    localparam int unsigned WordsPerBlock = BlockW / WordW;

    typedef enum logic [1:0] {
        TypeEnc = 2'b00,
        TypeDec = 2'b01,
        TypeKey = 2'b10,
        TypeIv  = 2'b11
    } blk_type_e;

    typedef enum logic {
        StFill = 1'b0,
        StHold = 1'b1
    } pack_state_e;

    function automatic logic [WordW-1:0] bswap32(input logic [WordW-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/stream_in_packer.sv
// Packs four 32-bit stream words into one 128-bit cipher block and hands it to the core.
// Define STREAM_IN_BSWAP_EN to byte-reverse each accepted word before packing.
module stream_in_packer
    import stream_in_packer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WordW-1:0]  s_data,
    input  logic [1:0]        s_type,
    input  logic              flush,
    input  logic              crypto_ready,
    output logic              out_valid,
    output logic [1:0]        out_type,
    output logic [BlockW-1:0] out_data,
    output logic              err_type
);

    pack_state_e       state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    blk_type_e         type_q, type_d;
    logic [BlockW-1:0] data_q, data_d;
    logic              out_valid_q, out_valid_d;
    logic [1:0]        out_type_q, out_type_d;
    logic [BlockW-1:0] out_data_q, out_data_d;
    logic              err_q, err_d;

    logic [WordW-1:0]  word_in;
    logic              accept;
    logic              release_ok;
    blk_type_e         in_type;

`ifdef STREAM_IN_BSWAP_EN
    assign word_in = bswap32(s_data);
`else
    assign word_in = s_data;
`endif

    assign in_type    = blk_type_e'(s_type);
    assign s_ready    = (state_q == StFill);
    assign accept     = s_valid & s_ready;
    // KEY/IV blocks are configuration loads and never stall on the core.
    assign release_ok = (type_q == TypeKey) || (type_q == TypeIv) || crypto_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        type_d      = type_q;
        data_d      = data_q;
        out_valid_d = 1'b0;
        out_type_d  = 2'b00;
        out_data_d  = '0;
        err_d       = 1'b0;

        if (flush) begin
            state_d = StFill;
            cnt_d   = 2'd0;
        end else begin
            case (state_q)
                StFill: begin
                    if (accept) begin
                        if (cnt_q == 2'd0) begin
                            type_d                       = in_type;
                            data_d[BlockW-1 -: WordW]    = word_in;
                            cnt_d                        = 2'd1;
                        end else if (in_type != type_q) begin
                            err_d = 1'b1;
                            cnt_d = 2'd0;
                        end else begin
                            unique case (cnt_q)
                                2'd1:    data_d[2*WordW +: WordW] = word_in;
                                2'd2:    data_d[WordW +: WordW]   = word_in;
                                default: data_d[0 +: WordW]       = word_in;
                            endcase
                            if (cnt_q == 2'd3) begin
                                state_d = StHold;
                                cnt_d   = 2'd0;
                            end else begin
                                cnt_d = cnt_q + 2'd1;
                            end
                        end
                    end
                end
                StHold: begin
                    if (release_ok) begin
                        out_valid_d = 1'b1;
                        out_type_d  = type_q;
                        out_data_d  = data_q;
                        state_d     = StFill;
                    end
                end
                default: state_d = StFill;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StFill;
            cnt_q       <= 2'd0;
            type_q      <= TypeEnc;
            data_q      <= '0;
            out_valid_q <= 1'b0;
            out_type_q  <= 2'b00;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            type_q      <= type_d;
            data_q      <= data_d;
            out_valid_q <= out_valid_d;
            out_type_q  <= out_type_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_type  = out_type_q;
    assign out_data  = out_data_q;
    assign err_type  = err_q;

endmodule

// File: doc/stream_in_packer.md
STREAM_IN_PACKER -- requirements
Module: stream_in_packer

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 rst_n  in  1  reset; synchronous, active-low.
REQ-003 s_valid  in  1  upstream word valid.
REQ-004 s_ready  out  1  packer accepts a word on (s_valid & s_ready).
REQ-005 s_data  in  32  upstream data word.
REQ-006 s_type  in  2  block type: 00 ENC, 01 DEC, 10 KEY, 11 IV.
REQ-007 flush  in  1  discard any partial or held block.
REQ-008 crypto_ready  in  1  cipher core accepts ENC/DEC blocks.
REQ-009 out_valid  out  1  one-cycle pulse, feeds cipher core vin.
REQ-010 out_type  out  2  block type, feeds cipher core tin.
REQ-011 out_data  out  128  packed block, feeds cipher core din.
REQ-012 err_type  out  1  one-cycle pulse on a type mismatch inside a block.

Function
REQ-013 The block SHALL pack four accepted 32-bit words into one 128-bit block: word 0 to [127:96], word 1 to [95:64], word 2 to [63:32], word 3 to [31:0].
REQ-014 The FSM SHALL have two states: FILL (s_ready=1, 2-bit word counter 0..3) and HOLD (s_ready=0, complete block held).
REQ-015 The block type SHALL be latched from s_type on word 0.
REQ-016 In FILL, an accepted word 3 with a matching type SHALL move the FSM to HOLD and reset the counter to 0; the counter wraps 3->0.
REQ-017 In FILL, an accepted word 1..3 whose s_type differs from the latched type SHALL pulse err_type for one cycle (registered, next cycle), discard that word and the partial block, and reset the counter to 0.
REQ-018 In HOLD, the release condition is met when the latched type is KEY or IV, or when crypto_ready=1.
REQ-019 When the release condition is met in HOLD, the block SHALL register out_valid=1 with out_type and out_data for exactly one cycle and return to FILL on the same edge.
REQ-020 In HOLD, an ENC/DEC block SHALL wait indefinitely while crypto_ready=0.
REQ-021 Minimum latency: word 3 is accepted at edge E; out_valid is high in the cycle after edge E+1. Peak throughput is one block per 5 cycles.
REQ-022 out_data and out_type SHALL be 0 whenever out_valid=0.
REQ-023 flush=1 SHALL clear the counter, force FILL, and suppress out_valid on that edge. flush wins over a simultaneous release and over a simultaneous accepted word, which is discarded.
REQ-024 s_ready SHALL depend only on registered state, never combinationally on s_valid, s_type or crypto_ready.
REQ-025 An out_valid pulse already registered before flush SHALL complete unchanged.

Reset
REQ-026 When rst_n=0 at a clock edge, the block SHALL set state=FILL, counter=0, latched type=00, the data register to 0, out_valid=0, out_type=0, out_data=0 and err_type=0.
REQ-027 A reset during FILL or HOLD SHALL drop the partial or held block silently, with no out_valid and no err_type.
REQ-028 s_ready SHALL be 1 in the first cycle after rst_n returns to 1.

Configuration
REQ-029 When STREAM_IN_BSWAP_EN is defined, each accepted s_data word SHALL be byte-reversed before packing ([7:0] to [31:24], and so on).
REQ-030 When STREAM_IN_BSWAP_EN is undefined, words SHALL be packed unmodified, and no other behaviour or timing SHALL differ.

Structure
REQ-031 The type codes (ENC/DEC/KEY/IV), the FSM state encoding and the block/word width constants SHALL live in the shared stream package, reused by the cipher core.
REQ-032 No sub-module is needed; packing, FSM and byte swap are implemented inline.

Verification
REQ-033 ENC block: words 00112233, 44556677, 8899AABB, CCDDEEFF, with crypto_ready=1 -> one out_valid pulse, out_type=00, out_data=00112233_44556677_8899AABB_CCDDEEFF, two cycles after word 3.
REQ-034 KEY block with crypto_ready=0 -> released immediately with out_type=10; a following DEC block holds (s_ready=0) until crypto_ready rises, then releases on the next cycle.
REQ-035 Type mismatch: word 0 type 00, word 2 type 01 -> err_type pulses once, no out_valid, next 4 words (type 01) produce one DEC block.
REQ-036 flush asserted in HOLD with crypto_ready rising on the same edge -> no out_valid, s_ready=1 the next cycle.
REQ-037 rst_n=0 after 2 words, then 4 new words -> exactly one block, containing only the post-reset words.
REQ-038 With STREAM_IN_BSWAP_EN defined, word 00112233 -> bits [127:96]=33221100.
